// File: rtl/fft_reorder_pingpong.sv
// fft_reorder_pingpong
//   Bit-reversal reorder buffer for the FFT output path. Takes radix-2 FFT results in
//   bit-reversed order as a complex stream and re-emits each frame in natural order.
//   Two banks in ping-pong let back-to-back frames flow at one sample per cycle.
//
// Parameters
//   LOG2N  : log2 of frame length (N = 2**LOG2N, LOG2N >= 2)
//   DW     : width of each of re / im (signed, passed through untouched)
//   BITREV : 1 = write at bitrev(index), 0 = natural write address (plain double buffer)
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : synchronous clear of banks, counters and output register
//   in_valid_i     : input sample valid
//   in_ready_o     : buffer can accept a sample this cycle
//   in_re_i/in_im_i: input sample (bit-reversed order)
//   out_valid_o    : output sample valid
//   out_ready_i    : sink accepts the output this cycle
//   out_re_o/out_im_o : output sample (natural order)
//   out_idx_o      : natural-order index of the current output sample
//
// Optional feature (macro FFT_REORDER_LAST_EN)
//   in_last_i      : frame-end marker from upstream (checked, never used for framing)
//   out_last_o     : high with the sample whose out_idx_o == N-1
//   frame_err_o    : sticky, set when in_last_i disagrees with the write counter

module fft_reorder_pingpong #(
    parameter int unsigned LOG2N  = 5,
    parameter int unsigned DW     = 17,
    parameter bit          BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
`ifdef FFT_REORDER_LAST_EN
    input  logic             in_last_i,
    output logic             out_last_o,
    output logic             frame_err_o,
`endif
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_re_i,
    input  logic [DW-1:0]    in_im_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_re_o,
    output logic [DW-1:0]    out_im_o,
    output logic [LOG2N-1:0] out_idx_o
);

    localparam int unsigned N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LastIdx = {LOG2N{1'b1}};

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Sample storage: bank index is the MSB of the address. Not reset.
    logic [2*DW-1:0] mem_q [2*N];

    // Per-bank state: 1 = FULL, 0 = FREE
    logic [1:0]       full_q, full_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;

    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_re_q, out_re_d;
    logic [DW-1:0]    out_im_q, out_im_d;
    logic [LOG2N-1:0] out_idx_q, out_idx_d;

`ifdef FFT_REORDER_LAST_EN
    logic out_last_q, out_last_d;
    logic frame_err_q, frame_err_d;
`endif

    logic            in_ready;
    logic            accept;
    logic            load;
    logic [LOG2N:0]  waddr;
    logic [2*DW-1:0] rdata;

    // in_ready depends only on registered write-side state, so a bank freed by the
    // reader shows up as ready one cycle later.
    assign in_ready = ~full_q[wbank_q];
    // Samples presented during a flush cycle are dropped.
    assign accept   = in_valid_i & in_ready & ~flush_i;
    assign load     = full_q[rbank_q] & (~out_valid_q | out_ready_i);
    assign waddr    = {wbank_q, (BITREV ? bitrev(wcnt_q) : wcnt_q)};
    assign rdata    = mem_q[{rbank_q, rcnt_q}];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[waddr] <= {in_re_i, in_im_i};
        end
    end

    always_comb begin
        full_d      = full_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
`ifdef FFT_REORDER_LAST_EN
        out_last_d  = out_last_q;
        frame_err_d = frame_err_q;
`endif

        // Write side. The reader can only free a different bank than the one being
        // filled, so the two updates to full_d never touch the same bit.
        if (accept) begin
            wcnt_d = wcnt_q + LOG2N'(1);
            if (wcnt_q == LastIdx) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
            end
`ifdef FFT_REORDER_LAST_EN
            if (in_last_i != (wcnt_q == LastIdx)) begin
                frame_err_d = 1'b1;
            end
`endif
        end

        // Read side
        if (load) begin
            out_valid_d = 1'b1;
            out_re_d    = rdata[2*DW-1:DW];
            out_im_d    = rdata[DW-1:0];
            out_idx_d   = rcnt_q;
            rcnt_d      = rcnt_q + LOG2N'(1);
`ifdef FFT_REORDER_LAST_EN
            out_last_d  = (rcnt_q == LastIdx);
`endif
            if (rcnt_q == LastIdx) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcnt_d          = '0;
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
`ifdef FFT_REORDER_LAST_EN
            out_last_d  = 1'b0;
`endif
        end

        if (flush_i) begin
            full_d      = '0;
            wbank_d     = 1'b0;
            rbank_d     = 1'b0;
            wcnt_d      = '0;
            rcnt_d      = '0;
            out_valid_d = 1'b0;
            out_re_d    = '0;
            out_im_d    = '0;
            out_idx_d   = '0;
`ifdef FFT_REORDER_LAST_EN
            out_last_d  = 1'b0;
            frame_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
`ifdef FFT_REORDER_LAST_EN
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
`ifdef FFT_REORDER_LAST_EN
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_re_o    = out_re_q;
    assign out_im_o    = out_im_q;
    assign out_idx_o   = out_idx_q;
`ifdef FFT_REORDER_LAST_EN
    assign out_last_o  = out_last_q;
    assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_fft_reorder_pingpong.sv
// Self-checking bench for fft_reorder_pingpong (LOG2N=5, DW=17).
// A BITREV=1 instance carries all scenarios; a BITREV=0 instance shares the stimulus and
// is checked on the first frame for natural-order pass-through.

module tb_fft_reorder_pingpong;

    localparam int unsigned LOG2N = 5;
    localparam int unsigned DW    = 17;
    localparam int          N     = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [DW-1:0]    in_re;
    logic [DW-1:0]    in_im;
    logic             out_ready;

    logic             in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic [LOG2N-1:0] out_idx;

    logic             nat_in_ready;
    logic             nat_out_valid;
    logic [DW-1:0]    nat_out_re;
    logic [DW-1:0]    nat_out_im;
    logic [LOG2N-1:0] nat_out_idx;

`ifdef FFT_REORDER_LAST_EN
    logic in_last;
    logic out_last;
    logic frame_err;
    logic nat_out_last;
    logic nat_frame_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_reorder_pingpong #(.LOG2N(LOG2N), .DW(DW), .BITREV(1'b1)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
`ifdef FFT_REORDER_LAST_EN
        .in_last_i   (in_last),
        .out_last_o  (out_last),
        .frame_err_o (frame_err),
`endif
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_re_i     (in_re),
        .in_im_i     (in_im),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_re_o    (out_re),
        .out_im_o    (out_im),
        .out_idx_o   (out_idx)
    );

    fft_reorder_pingpong #(.LOG2N(LOG2N), .DW(DW), .BITREV(1'b0)) u_dut_nat (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
`ifdef FFT_REORDER_LAST_EN
        .in_last_i   (in_last),
        .out_last_o  (nat_out_last),
        .frame_err_o (nat_frame_err),
`endif
        .in_valid_i  (in_valid),
        .in_ready_o  (nat_in_ready),
        .in_re_i     (in_re),
        .in_im_i     (in_im),
        .out_valid_o (nat_out_valid),
        .out_ready_i (out_ready),
        .out_re_o    (nat_out_re),
        .out_im_o    (nat_out_im),
        .out_idx_o   (nat_out_idx)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int br5(input int a);
        int r = 0;
        for (int i = 0; i < 5; i++) begin
            if (a[i]) r = r | (1 << (4 - i));
        end
        return r;
    endfunction

    function automatic int sre(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one 32-sample frame, re = base+k, im = -(base+k); waits (bounded) on in_ready.
    task automatic send_frame(input int base, input int last_pos);
        for (int k = 0; k < N; k++) begin
            int guard = 0;
            in_valid = 1'b1;
            in_re    = DW'(base + k);
            in_im    = DW'(-(base + k));
`ifdef FFT_REORDER_LAST_EN
            in_last  = (k == last_pos);
`endif
            while (!in_ready && guard < 200) begin
                step();
                guard++;
            end
            if (guard >= 200) check_val("send_ready_timeout", guard, 0);
            step();
        end
        in_valid = 1'b0;
`ifdef FFT_REORDER_LAST_EN
        in_last  = 1'b0;
`endif
    endtask

    // Expect one frame in natural order with out_ready held high.
    task automatic expect_frame(input int base, input string tag);
        int waited = 0;
        while (!out_valid && waited < 8) begin
            step();
            waited++;
        end
        check_val({tag, "_start"}, int'(out_valid), 1);
        for (int j = 0; j < N; j++) begin
            check_val($sformatf("%s_idx%0d", tag, j), int'(out_idx), j);
            check_val($sformatf("%s_re%0d", tag, j), sre(out_re), base + br5(j));
            check_val($sformatf("%s_im%0d", tag, j), sre(out_im), -(base + br5(j)));
`ifdef FFT_REORDER_LAST_EN
            check_val($sformatf("%s_last%0d", tag, j), int'(out_last), int'(j == N - 1));
`endif
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        int gaps;
        int stalls;
        int acc;
        bit started;
        bit take;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
`ifdef FFT_REORDER_LAST_EN
        in_last   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Reset state
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_re", sre(out_re), 0);
        check_val("rst_out_im", sre(out_im), 0);
        check_val("rst_out_idx", int'(out_idx), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_nat_in_ready", int'(nat_in_ready), 1);

        // Single frame: reorder, latency, natural-order instance
        send_frame(0, N - 1);
        check_val("t1_valid_at_accept", int'(out_valid), 0);
        step();
        check_val("t1_valid_next", int'(out_valid), 1);
        check_val("t1_nat_valid_next", int'(nat_out_valid), 1);
        for (int j = 0; j < N; j++) begin
            check_val($sformatf("t1_idx%0d", j), int'(out_idx), j);
            check_val($sformatf("t1_re%0d", j), sre(out_re), br5(j));
            check_val($sformatf("t1_im%0d", j), sre(out_im), -br5(j));
            check_val($sformatf("t1_nat_re%0d", j), sre(nat_out_re), j);
            check_val($sformatf("t1_nat_idx%0d", j), int'(nat_out_idx), j);
            step();
        end
        check_val("t1_valid_end", int'(out_valid), 0);

        // Three back-to-back frames at full rate
        k = 0; n = 0; gaps = 0; stalls = 0; started = 1'b0;
        for (int c = 0; c < 300 && n < 3 * N; c++) begin
            if (out_valid) begin
                check_val($sformatf("t2_idx%0d", n), int'(out_idx), n % N);
                check_val($sformatf("t2_re%0d", n), sre(out_re),
                          1000 + (n / N) * N + br5(n % N));
                started = 1'b1;
                n++;
            end else if (started) begin
                gaps++;
            end
            take = 1'b0;
            if (k < 3 * N) begin
                in_valid = 1'b1;
                in_re    = DW'(1000 + k);
                in_im    = DW'(-(1000 + k));
                if (!in_ready) stalls++;
                take = in_ready;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (take) k++;
        end
        in_valid = 1'b0;
        check_val("t2_outputs", n, 3 * N);
        check_val("t2_in_stalls", stalls, 0);
        check_val("t2_out_gaps", gaps, 0);
        step();
        check_val("t2_valid_end", int'(out_valid), 0);
        check_val("t2_ready_end", int'(in_ready), 1);

        // Back-pressure: both banks fill, output held stable
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 100; c++) begin
            if (!in_ready) break;
            in_valid = 1'b1;
            in_re    = DW'(2000 + acc);
            in_im    = DW'(-(2000 + acc));
            step();
            acc++;
        end
        in_valid = 1'b0;
        check_val("t3_accepts", acc, 2 * N);
        check_val("t3_valid_stall", int'(out_valid), 1);
        check_val("t3_re_stall", sre(out_re), 2000);
        repeat (3) step();
        check_val("t3_re_held", sre(out_re), 2000);
        check_val("t3_idx_held", int'(out_idx), 0);
        check_val("t3_ready_held", int'(in_ready), 0);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 2 * N; c++) begin
            if (out_valid) begin
                check_val($sformatf("t3_idx%0d", n), int'(out_idx), n % N);
                check_val($sformatf("t3_re%0d", n), sre(out_re),
                          2000 + (n / N) * N + br5(n % N));
                if (n == N - 2) check_val("t3_ready_before_free", int'(in_ready), 0);
                if (n == N - 1) check_val("t3_ready_after_free", int'(in_ready), 1);
                n++;
            end
            step();
        end
        check_val("t3_outputs", n, 2 * N);
        check_val("t3_ready_end", int'(in_ready), 1);

        // Flush in the middle of frame 2 (input 10 dropped)
        send_frame(300, N - 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_re    = DW'(332 + i);
            in_im    = DW'(-(332 + i));
            step();
        end
        flush = 1'b1;
        in_re = DW'(342);
        in_im = DW'(-342);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("t4_flush_valid", int'(out_valid), 0);
        check_val("t4_flush_ready", int'(in_ready), 1);
        check_val("t4_flush_idx", int'(out_idx), 0);
        check_val("t4_flush_re", sre(out_re), 0);
        send_frame(700, N - 1);
        expect_frame(700, "t4");

        // Asynchronous reset in the middle of output
        send_frame(500, N - 1);
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        check_val("t5_rst_valid", int'(out_valid), 0);
        check_val("t5_rst_re", sre(out_re), 0);
        check_val("t5_rst_im", sre(out_im), 0);
        check_val("t5_rst_idx", int'(out_idx), 0);
        check_val("t5_rst_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check_val("t5_post_valid", int'(out_valid), 0);
        send_frame(600, N - 1);
        expect_frame(600, "t5");

`ifdef FFT_REORDER_LAST_EN
        check_val("t6_err_clean", int'(frame_err), 0);
        send_frame(800, N - 2);
        check_val("t6_err_set", int'(frame_err), 1);
        expect_frame(800, "t6");
        check_val("t6_err_sticky", int'(frame_err), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("t6_err_flushed", int'(frame_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_reorder_pingpong.md
Name: fft_reorder_pingpong

Overview:
Parametrised bit-reversal reorder buffer for the FFT output path. Accepts radix-2 FFT results in bit-reversed order as a complex (re/im) stream and re-emits each frame in natural order. Two banks in ping-pong allow continuous back-to-back frames at 1 sample/cycle. Valid/ready handshakes on both sides. Sits between the last butterfly stage and the result sink.

Parameters:
LOG2N, 5, log2 of frame length; N = 2**LOG2N points per frame (LOG2N >= 2)
DW, 17, signed sample width of each of re and im
BITREV, 1, 1: write address = bit-reverse(input index); 0: natural write address (pure double buffer)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous clear of banks, counters and output register
in_valid  input  1  input sample valid
in_ready  output  1  buffer can accept a sample this cycle
in_re  input  DW  signed real part
in_im  input  DW  signed imaginary part
out_valid  output  1  output sample valid
out_ready  input  1  sink accepts output this cycle
out_re  output  DW  signed real part, natural order
out_im  output  DW  signed imaginary part, natural order
out_idx  output  LOG2N  natural-order index of current output sample

Behaviour:
- Storage: 2 banks x N entries x 2*DW bits. Per-bank state: FREE or FULL (1 bit each).
- Write side: wbank (1b), wcnt (LOG2N b). in_ready = (bank[wbank] == FREE), combinational. Accept = in_valid & in_ready.
- On accept: bank[wbank][addr] <= {in_re,in_im}, addr = BITREV ? bitrev(wcnt) : wcnt. wcnt++. If wcnt == N-1: bank[wbank] <= FULL, wbank toggles, wcnt <= 0 (wrap).
- Read side: rbank (1b), rcnt (LOG2N b). Output register {out_valid,out_re,out_im,out_idx}. Load enable = bank[rbank]==FULL & (!out_valid | out_ready).
- On load: out_re/out_im <= bank[rbank][rcnt], out_idx <= rcnt, out_valid <= 1, rcnt++. If rcnt == N-1: bank[rbank] <= FREE, rbank toggles, rcnt <= 0.
- If out_valid & out_ready & no load: out_valid <= 0. Output data held stable while out_valid & !out_ready.
- Latency: last input of a frame accepted in cycle T -> out_valid=1 with out_idx=0 in cycle T+1 (bank becomes FULL at edge T, loaded at edge T+1).
- Throughput: with out_ready=1 constantly, continuous input never stalls; output sustains 1 sample/cycle.
- Same-bank free and fill cannot coincide (wbank != rbank whenever both active). Bank freed at edge T -> in_ready may rise in cycle T+1 (no combinational path from read to write).
- Both banks FULL -> in_ready=0 until read side frees one.
- flush (sync, highest priority after reset): both banks FREE, wbank=rbank=0, wcnt=rcnt=0, out_valid=0; in-flight data discarded; in_ready=1 next cycle. Inputs in the flush cycle are dropped.
- Reset values: out_valid=0, out_re=0, out_im=0, out_idx=0, in_ready=1 (both banks FREE). Reset mid-frame discards all partial/complete frames. Memory contents need not be reset.
- No arithmetic on data; widths pass through unchanged, sign preserved.

Optional Feature:
FFT_REORDER_LAST_EN: adds ports in_last (input 1), out_last (output 1) and frame_err (output 1).
- With: out_last=1 with the sample where out_idx==N-1. frame_err is sticky (cleared by reset/flush only), set when an accepted sample has in_last != (wcnt==N-1). Framing still follows wcnt; in_last never realigns. Reset: out_last=0, frame_err=0.
- Without: those ports and logic absent; framing purely count-based.

Test Plan:
- LOG2N=5, BITREV=1, out_ready=1; 32 inputs re=k, im=-k -> out_re sequence 0,16,8,24,4,20,...,15,31 with out_im its negation, out_idx 0..31; first out_valid one cycle after 32nd accept.
- 3 back-to-back frames, in_valid=1, out_ready=1 -> in_ready never low, 96 outputs, no out_valid gap after the first.
- out_ready=0 held; stream inputs -> in_ready drops after 64 accepts; raise out_ready -> 32 outputs, then in_ready=1 next cycle; out_re stable while stalled.
- flush at input 10 of frame 2 -> out_valid=0 next cycle; new 32-sample frame reorders correctly from index 0. Repeat with rst_n pulse mid-output -> all outputs 0, in_ready=1.
- BITREV=0 -> out_re = 0,1,2,...,31 (order preserved), same latency.
- FFT_REORDER_LAST_EN: in_last at k=31 -> out_last only at out_idx=31, frame_err=0; in_last at k=30 -> frame_err=1 and stays 1 until flush.
